// File: rtl/serial_frame_rx_pkg.sv
// serial_frame_pkg: shared states, defaults and parity helper for serial_frame_rx.
package serial_frame_pkg;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_STOP_LEN = 1;

    typedef enum logic [1:0] {IDLE, SHIFT, PARITY, STOP} state_t;

    function automatic logic even_parity(logic [31:0] d, int w);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 32; i++) if (i < w) p ^= d[i];
        return p;
    endfunction
endpackage

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: deframes serial line a into DATA_W words on a valid/ready port.
// Define SERIAL_FRAME_RX_PARITY_EN to add an even-parity bit and the perr_o port.
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int STOP_LEN = DEF_STOP_LEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a,
    output logic              b,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              ferr_o,
`ifdef SERIAL_FRAME_RX_PARITY_EN
    output logic              perr_o,
`endif
    output logic              ovr_o
);
    localparam int CW = $clog2(DATA_W > STOP_LEN ? DATA_W : STOP_LEN) + 1;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [DATA_W-1:0] sh, sh_n, data_n;
    logic              b_n, valid_n, ferr_n, ovr_n, load;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    logic              par_bad, par_bad_n, perr_n;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sh_n    = sh;
        ferr_n  = 1'b0;
        ovr_n   = 1'b0;
        load    = 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
        par_bad_n = par_bad;
        perr_n    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (a) state_n = SHIFT;
                cnt_n = '0;
            end
            SHIFT: begin
                // LSB arrives first, so after DATA_W shifts it sits at bit 0
                sh_n  = DATA_W'({a, sh} >> 1);
                cnt_n = cnt + CW'(1);
                if (cnt == CW'(DATA_W - 1)) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
                    state_n = PARITY;
`else
                    state_n = STOP;
`endif
                    cnt_n = '0;
                end
            end
`ifdef SERIAL_FRAME_RX_PARITY_EN
            PARITY: begin
                par_bad_n = a != even_parity(32'(sh), DATA_W);
                state_n   = STOP;
            end
`endif
            STOP: begin
                cnt_n = cnt + CW'(1);
                if (a || cnt == CW'(STOP_LEN - 1)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
                if (a) ferr_n = 1'b1;
                else if (cnt == CW'(STOP_LEN - 1)) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
                    if (par_bad) perr_n = 1'b1; else
`endif
                    if (!valid_o || ready_i) load = 1'b1; else ovr_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        b_n     = state_n != IDLE;
        valid_n = load | (valid_o & ~ready_i);
        data_n  = load ? sh : data_o;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            sh      <= '0;
            b       <= 1'b0;
            data_o  <= '0;
            valid_o <= 1'b0;
            ferr_o  <= 1'b0;
            ovr_o   <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            par_bad <= 1'b0;
            perr_o  <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            sh      <= sh_n;
            b       <= b_n;
            data_o  <= data_n;
            valid_o <= valid_n;
            ferr_o  <= ferr_n;
            ovr_o   <= ovr_n;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            par_bad <= par_bad_n;
            perr_o  <= perr_n;
`endif
        end
    end
endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Receive-side consumer of the `ifCheck` interface.
- The bench drives serial line `a` through the interface clocking block (output `a`). This block deframes `a` into parallel words.
- It drives status line `b` back; the bench samples `b` through the clocking block (input `b`), so `b` is bound to the interface's `dut` modport.
- Parallel words leave on a valid/ready port toward downstream logic or the scoreboard.

Parameters:
- DATA_W, 8, payload bits per frame (legal range 1..32).
- STOP_LEN, 1, number of stop bits (legal range 1..4); every stop bit must be 0.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a  input  1  serial line; sampled only at the rising edge of clk.
- b  output  1  registered busy flag; high while a frame is in progress.
- data_o  output  DATA_W  received payload.
- valid_o  output  1  data_o holds an unconsumed word.
- ready_i  input  1  downstream accepts; a transfer occurs when valid_o && ready_i at a rising edge.
- ferr_o  output  1  one-cycle pulse on framing error.
- ovr_o  output  1  one-cycle pulse when a good frame is dropped because the output is still full.

Behaviour:
- Reset (async assert, sync release): state=IDLE, b=0, data_o=0, valid_o=0, ferr_o=0, ovr_o=0, shift register=0, bit counter=0.
- Frame format: start bit (a=1), then DATA_W data bits LSB first, then STOP_LEN stop bits (a=0). Idle line is 0.
- State machine:
  - IDLE: a=1 sampled → SHIFT, cnt=0.
  - SHIFT: shift `a` into bit cnt; cnt==DATA_W-1 → STOP, cnt=0.
  - STOP: a must be 0 on every stop bit.
    - a=1 on any stop bit → ferr_o pulse, frame discarded, → IDLE. That stop-position 1 is NOT taken as a new start.
    - Last stop bit good → DONE action, → IDLE.
- DONE action, on the same edge as the last stop bit:
  - If valid_o=0, or valid_o=1 && ready_i=1 (simultaneous pop): load data_o, valid_o=1.
  - Else: keep the old word, pulse ovr_o, drop the new frame.
- Busy flag: b=1 in every cycle where next-state is SHIFT or STOP, so it is registered with no comb path from a. b rises on the edge that samples the start bit and falls on the edge that samples the last stop bit.
- Latency: valid_o rises on the edge that samples the last stop bit. Frame period = 1+DATA_W+STOP_LEN cycles.
- Back-to-back frames: a start bit sampled in IDLE on the cycle immediately after a stop bit is accepted. There is no mandatory idle gap.
- Output hold: valid_o && !ready_i → data_o and valid_o hold stable.
- Width rules: cnt width is $clog2(max(DATA_W,STOP_LEN))+1; no wrap beyond its limit.
- Reset mid-frame: the partial frame is lost, and valid_o is cleared even if a word was pending.

Optional Feature:
- Macro: SERIAL_FRAME_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between SHIFT and STOP; it samples one even-parity bit.
  - Mismatch → perr_o pulses for one cycle on the edge after the stop bits, and the frame is dropped.
  - perr_o is an extra 1-bit output port, reset 0.
  - Frame period becomes 2+DATA_W+STOP_LEN cycles.
- Undefined: no PARITY state, no perr_o port.

Decomposition:
- Package serial_frame_pkg:
  - state enum: IDLE, SHIFT, PARITY, STOP.
  - default DATA_W and STOP_LEN localparams.
  - function even_parity(logic [31:0] d, int w).
- No sub-module. The single always_ff FSM plus output register is natural; the output stage is small enough to stay inline.

Test Plan:
- Single frame, DATA_W=8: a=1, then 1,0,1,0,0,1,0,1 (0xA5 LSB first), then 0, with ready_i=1 → data_o=8'hA5, valid_o high for 1 cycle at cycle 10; b high cycles 1-10.
- Framing error: same frame with stop bit a=1 → ferr_o pulses at cycle 10, valid_o stays 0, FSM returns to IDLE.
- Overrun: frames 0x3C then 0xC3 back-to-back with ready_i=0 → data_o stays 0x3C, ovr_o pulses at end of second frame.
- Simultaneous pop: ready_i asserted on the same edge the second frame completes → data_o becomes 0xC3, valid_o stays 1, no ovr_o.
- Reset mid-frame: deassert rst_n after 4 data bits with a pending word → all outputs 0 immediately, b=0. After release, a clean frame 0x01 is received correctly.
- PARITY_EN build: frame 0x07 with parity bit 0 (wrong; correct is 1) → perr_o pulse, no valid_o. With parity bit 1 → data_o=0x07.
